// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: power-up init, then fixed-priority grants (refresh > write > read).
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module sdram_arbit #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned BA_W        = 2,
    parameter int unsigned DQ_W        = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              flag_init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              flag_ref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    output logic              ref_en,
    input  logic              wr_req,
    input  logic              flag_wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              wr_dq_oe,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic              flag_rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_ba,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [DQ_W-1:0]   sdram_dq_o,
    output logic              sdram_dq_oe,
    output logic              arb_err
);

    localparam logic [3:0] CmdNop = 4'b0111;

    typedef enum logic [2:0] {StInit, StArbit, StAref, StWrite, StRead} state_e;

    state_e state;
    logic   done;
    logic   expired;

    always_comb begin
        done = 1'b0;
        unique case (state)
            StAref:  done = flag_ref_end;
            StWrite: done = flag_wr_end;
            StRead:  done = flag_rd_end;
            default: done = 1'b0;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // A completion flag on the final cycle counts as a normal exit.
    assign expired = (state inside {StAref, StWrite, StRead}) && (cnt == CntMax) && !done;
`else
    assign expired = 1'b0;
    assign arb_err = 1'b0;
`endif

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= StInit;
            ref_en    <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            sdram_cke <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt       <= '0;
            arb_err   <= 1'b0;
`endif
        end else begin
            sdram_cke <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            arb_err   <= expired;
            cnt       <= (state == StArbit || state == StInit) ? '0 : cnt + 1'b1;
`endif
            unique case (state)
                StInit: begin
                    if (flag_init_end) state <= StArbit;
                end
                StArbit: begin
                    if (ref_req) begin
                        state  <= StAref;
                        ref_en <= 1'b1;
                    end else if (wr_req) begin
                        state  <= StWrite;
                        wr_en  <= 1'b1;
                    end else if (rd_req) begin
                        state  <= StRead;
                        rd_en  <= 1'b1;
                    end
                end
                StAref, StWrite, StRead: begin
                    if (done || expired) begin
                        state  <= StArbit;
                        ref_en <= 1'b0;
                        wr_en  <= 1'b0;
                        rd_en  <= 1'b0;
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

    // Pins stay at NOP until the first edge after reset release (cke doubles as "out of reset").
    always_comb begin
        sdram_cmd   = CmdNop;
        sdram_addr  = '0;
        sdram_ba    = '0;
        sdram_dq_oe = 1'b0;
        sdram_dq_o  = sdram_cke ? wr_dq : '0;
        if (sdram_cke) begin
            unique case (state)
                StInit: begin
                    sdram_cmd  = init_cmd;
                    sdram_addr = init_addr;
                end
                StAref: begin
                    sdram_cmd  = aref_cmd;
                    sdram_addr = aref_addr;
                end
                StWrite: begin
                    sdram_cmd   = wr_cmd;
                    sdram_addr  = wr_addr;
                    sdram_ba    = wr_ba;
                    sdram_dq_oe = wr_dq_oe;
                end
                StRead: begin
                    sdram_cmd  = rd_cmd;
                    sdram_addr = rd_addr;
                    sdram_ba   = rd_ba;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: init, priority ordering, pin mux, async reset, watchdog.
// Build with +define+ARB_TIMEOUT_EN to check the watchdog path.
module tb_sdram_arbit;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned DQ_W   = 16;

    logic              sclk = 1'b0;
    logic              s_rst_n;
    logic              flag_init_end;
    logic [3:0]        init_cmd   = 4'b0010;
    logic [ADDR_W-1:0] init_addr  = 13'h0400;
    logic              ref_req, flag_ref_end;
    logic [3:0]        aref_cmd   = 4'b0001;
    logic [ADDR_W-1:0] aref_addr  = 13'h0111;
    logic              ref_en;
    logic              wr_req, flag_wr_end;
    logic [3:0]        wr_cmd     = 4'b0100;
    logic [ADDR_W-1:0] wr_addr    = 13'h0222;
    logic [BA_W-1:0]   wr_ba      = 2'd2;
    logic [DQ_W-1:0]   wr_dq      = 16'hA5A5;
    logic              wr_dq_oe   = 1'b1;
    logic              wr_en;
    logic              rd_req, flag_rd_end;
    logic [3:0]        rd_cmd     = 4'b0101;
    logic [ADDR_W-1:0] rd_addr    = 13'h0333;
    logic [BA_W-1:0]   rd_ba      = 2'd3;
    logic              rd_en;
    logic              sdram_cke;
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BA_W-1:0]   sdram_ba;
    logic [DQ_W-1:0]   sdram_dq_o;
    logic              sdram_dq_oe;
    logic              arb_err;

    int n_tests = 0;
    int n_fail  = 0;
    int hi;
    int grant_seen;

    sdram_arbit #(
        .ADDR_W     (ADDR_W),
        .BA_W       (BA_W),
        .DQ_W       (DQ_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .sclk         (sclk),
        .s_rst_n      (s_rst_n),
        .flag_init_end(flag_init_end),
        .init_cmd     (init_cmd),
        .init_addr    (init_addr),
        .ref_req      (ref_req),
        .flag_ref_end (flag_ref_end),
        .aref_cmd     (aref_cmd),
        .aref_addr    (aref_addr),
        .ref_en       (ref_en),
        .wr_req       (wr_req),
        .flag_wr_end  (flag_wr_end),
        .wr_cmd       (wr_cmd),
        .wr_addr      (wr_addr),
        .wr_ba        (wr_ba),
        .wr_dq        (wr_dq),
        .wr_dq_oe     (wr_dq_oe),
        .wr_en        (wr_en),
        .rd_req       (rd_req),
        .flag_rd_end  (flag_rd_end),
        .rd_cmd       (rd_cmd),
        .rd_addr      (rd_addr),
        .rd_ba        (rd_ba),
        .rd_en        (rd_en),
        .sdram_cke    (sdram_cke),
        .sdram_cmd    (sdram_cmd),
        .sdram_addr   (sdram_addr),
        .sdram_ba     (sdram_ba),
        .sdram_dq_o   (sdram_dq_o),
        .sdram_dq_oe  (sdram_dq_oe),
        .arb_err      (arb_err)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    function automatic logic [2:0] grants();
        return {ref_en, wr_en, rd_en};
    endfunction

    initial begin
        s_rst_n = 1'b0;
        flag_init_end = 1'b0;
        ref_req = 1'b0; flag_ref_end = 1'b0;
        wr_req  = 1'b0; flag_wr_end  = 1'b0;
        rd_req  = 1'b0; flag_rd_end  = 1'b0;
        #1;
        chk("rst_cmd", 32'(sdram_cmd), 32'h7);
        chk("rst_addr_ba", 32'({sdram_addr, sdram_ba}), 32'h0);
        chk("rst_dq", 32'({sdram_dq_o, sdram_dq_oe}), 32'h0);
        chk("rst_cke", 32'(sdram_cke), 32'h0);
        chk("rst_grants", 32'({grants(), arb_err}), 32'h0);
        step(); step();
        s_rst_n = 1'b1;
        ref_req = 1'b1;

        // INIT ignores requests
        grant_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grants() != 3'b000) grant_seen++;
        end
        chk("init_no_grant", 32'(grant_seen), 32'h0);
        chk("init_cmd", 32'(sdram_cmd), 32'(init_cmd));
        chk("init_addr", 32'(sdram_addr), 32'(init_addr));
        chk("init_cke", 32'(sdram_cke), 32'h1);

        // Refresh grant: high from 2nd cycle after init end for 11 cycles
        flag_init_end = 1'b1;
        step();
        chk("arbit_nop", 32'(sdram_cmd), 32'h7);
        chk("arbit_no_grant", 32'(grants()), 32'h0);
        step();
        chk("aref_grant", 32'(grants()), 32'b100);
        chk("aref_cmd", 32'(sdram_cmd), 32'(aref_cmd));
        chk("aref_addr_ba", 32'({sdram_addr, sdram_ba}), 32'({aref_addr, 2'b00}));
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ref_en) hi++;
        end
        flag_ref_end = 1'b1;
        ref_req = 1'b0;
        step();
        flag_ref_end = 1'b0;
        chk("aref_len", 32'(hi), 32'd11);
        chk("aref_drop", 32'(grants()), 32'h0);
        chk("aref_end_nop", 32'(sdram_cmd), 32'h7);
        step();
        chk("idle_stays", 32'({grants(), sdram_cmd}), 32'h7);

        // All three requests at once: AREF, NOP, WRITE, NOP, READ
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        step();
        chk("prio_aref", 32'(grants()), 32'b100);
        flag_ref_end = 1'b1; ref_req = 1'b0;
        step();
        flag_ref_end = 1'b0;
        chk("gap1_nop", 32'({grants(), sdram_cmd}), 32'h7);
        step();
        chk("prio_write", 32'(grants()), 32'b010);
        chk("wr_cmd", 32'(sdram_cmd), 32'(wr_cmd));
        chk("wr_addr_ba", 32'({sdram_addr, sdram_ba}), 32'({wr_addr, wr_ba}));
        chk("wr_dq_oe", 32'(sdram_dq_oe), 32'h1);
        chk("wr_dq", 32'(sdram_dq_o), 32'hA5A5);
        flag_wr_end = 1'b1; wr_req = 1'b0;
        step();
        flag_wr_end = 1'b0;
        chk("gap2_nop", 32'({grants(), sdram_cmd}), 32'h7);
        chk("gap2_dq_oe", 32'(sdram_dq_oe), 32'h0);
        step();
        chk("prio_read", 32'(grants()), 32'b001);
        chk("rd_cmd", 32'(sdram_cmd), 32'(rd_cmd));
        chk("rd_addr_ba", 32'({sdram_addr, sdram_ba}), 32'({rd_addr, rd_ba}));
        chk("rd_dq_oe", 32'(sdram_dq_oe), 32'h0);

        // Asynchronous reset mid-READ
        step();
        chk("rd_hold", 32'(rd_en), 32'h1);
        #3;
        s_rst_n = 1'b0;
        #1;
        chk("async_rd_en", 32'(rd_en), 32'h0);
        chk("async_nop", 32'(sdram_cmd), 32'h7);
        flag_init_end = 1'b0;
        step();
        s_rst_n = 1'b1;
        step();
        chk("reinit_cmd", 32'(sdram_cmd), 32'(init_cmd));
        step(); step();
        chk("reinit_no_grant", 32'(grants()), 32'h0);

        // Write without completion: watchdog (if built) or indefinite hold
        rd_req = 1'b0;
        flag_init_end = 1'b1;
        wr_req = 1'b1;
        step();
        step();
        hi = 0;
        if (wr_en) hi++;
        for (int i = 0; i < 15; i++) begin
            step();
            if (wr_en) hi++;
        end
        chk("wd_hold_len", 32'(hi), 32'd16);
        step();
`ifdef ARB_TIMEOUT_EN
        chk("wd_drop", 32'(wr_en), 32'h0);
        chk("wd_err", 32'(arb_err), 32'h1);
        chk("wd_nop", 32'(sdram_cmd), 32'h7);
        wr_req = 1'b0;
        step();
        chk("wd_err_pulse", 32'(arb_err), 32'h0);
        chk("wd_idle", 32'(grants()), 32'h0);
`else
        chk("nowd_hold", 32'(wr_en), 32'h1);
        chk("nowd_err", 32'(arb_err), 32'h0);
        wr_req = 1'b0;
        step();
        chk("nowd_hold2", 32'(wr_en), 32'h1);
        flag_wr_end = 1'b1;
        step();
        flag_wr_end = 1'b0;
        chk("nowd_end", 32'({grants(), sdram_cmd}), 32'h7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
